timer: RTL and testbench

- Free-running clock divider for the CHIP-8 core.
- Derives two single-cycle strobes from the system clock:
  - a CPU instruction tick, which paces the fetch/execute loop;
  - a 60 Hz tick, which drives the delay and sound timer decrement.
- Sits at top level beside the CPU. It has no data inputs, only clock and reset.

---
 rtl/timer.sv | 60 ++++++
 tb/tb_timer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer.sv
// CHIP-8 clock divider: free-running CPU-instruction and 60 Hz single-cycle strobes.
// Optional TIMER_PAUSE_EN adds a pause input that freezes both counters.
module timer #(
    parameter int CLOCK_SPEED = 100000,
    parameter int CPU_SPEED   = 500,
    parameter int TICK_HZ     = 60
) (
    input  logic clk,
    input  logic rst_n,
`ifdef TIMER_PAUSE_EN
    input  logic pause,
`endif
    output logic timer_cpu_tick,
    output logic timer_60hz_tick
);

    localparam int CPU_DIV = (CPU_SPEED > 0) ? CLOCK_SPEED / CPU_SPEED : 1;
    localparam int HZ_DIV  = (TICK_HZ > 0) ? CLOCK_SPEED / TICK_HZ : 1;
    localparam int CPU_W   = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int HZ_W    = (HZ_DIV > 1) ? $clog2(HZ_DIV) : 1;

    localparam logic [CPU_W-1:0] CPU_MAX = CPU_W'(CPU_DIV - 1);
    localparam logic [HZ_W-1:0]  HZ_MAX  = HZ_W'(HZ_DIV - 1);

    // A rate above the system clock truncates its divisor to zero.
    if (CPU_SPEED < 1 || TICK_HZ < 1 || CPU_SPEED > CLOCK_SPEED || TICK_HZ > CLOCK_SPEED) begin : g_bad_rate
        $error("timer: CPU_SPEED and TICK_HZ must lie in 1..CLOCK_SPEED");
    end

    logic             run;
    logic [CPU_W-1:0] cpu_cnt;
    logic [HZ_W-1:0]  hz_cnt;

`ifdef TIMER_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_cnt <= '0;
        end else if (run) begin
            cpu_cnt <= (cpu_cnt == CPU_MAX) ? '0 : cpu_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz_cnt <= '0;
        end else if (run) begin
            hz_cnt <= (hz_cnt == HZ_MAX) ? '0 : hz_cnt + 1'b1;
        end
    end

    // Strobes decode the registered count directly, so they read 1 throughout reset.
    assign timer_cpu_tick  = (cpu_cnt == '0);
    assign timer_60hz_tick = (hz_cnt == '0);

endmodule

// File: tb/tb_timer.sv
// Bench for timer: default divisors plus small-divisor and divide-by-one instances,
// checked every cycle against an edge-count modulo model.
module tb_timer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic pause = 1'b0;

    always #5 clk = ~clk;

    logic d_cpu, d_hz, s_cpu, s_hz, o_cpu, o_hz;
    logic [5:0] act;

    // Defaults: divisors 200 and 1666.
    timer u_def (
        .clk(clk), .rst_n(rst_n),
`ifdef TIMER_PAUSE_EN
        .pause(pause),
`endif
        .timer_cpu_tick(d_cpu), .timer_60hz_tick(d_hz)
    );

    // Divisors 6 and 4, so coincidence every 12 cycles.
    timer #(.CLOCK_SPEED(60), .CPU_SPEED(10), .TICK_HZ(15)) u_small (
        .clk(clk), .rst_n(rst_n),
`ifdef TIMER_PAUSE_EN
        .pause(pause),
`endif
        .timer_cpu_tick(s_cpu), .timer_60hz_tick(s_hz)
    );

    // Divisor 1 (constant tick) and truncating divisor 50/7 = 7.
    timer #(.CLOCK_SPEED(50), .CPU_SPEED(50), .TICK_HZ(7)) u_one (
        .clk(clk), .rst_n(rst_n),
`ifdef TIMER_PAUSE_EN
        .pause(pause),
`endif
        .timer_cpu_tick(o_cpu), .timer_60hz_tick(o_hz)
    );

    assign act = {d_cpu, d_hz, s_cpu, s_hz, o_cpu, o_hz};

    int n;          // counting edges since reset release (paused edges excluded)
    int edges;      // raw edges since reset release
    int compared   = 0;
    int mismatched = 0;

    function automatic logic [5:0] model(input int k);
        return {k % 200 == 0, k % 1666 == 0, k % 6 == 0, k % 4 == 0, 1'b1, k % 7 == 0};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            n = 0;
            edges = 0;
        end else begin
            edges++;
            if (!pause) n++;
        end
        #1;
    endtask

    task automatic release_reset();
        #3 rst_n = 1'b1;
        n = 0;
        edges = 0;
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if (act !== 6'b111111) begin
            mismatched++;
            $display("FAIL power_up: got %b want %b", act, 6'b111111);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (act !== 6'b111111) begin
            mismatched++;
            $display("FAIL reset_async: got %b want %b", act, 6'b111111);
        end
        repeat (3) step();
        compared++;
        if (act !== 6'b111111) begin
            mismatched++;
            $display("FAIL reset_held: got %b want %b", act, 6'b111111);
        end
        release_reset();
    endtask

    task automatic test_count();
        for (int i = 1; i <= 3400; i++) begin
            step();
            compared++;
            if (act !== model(n)) begin
                mismatched++;
                $display("FAIL count_n%0d: got %b want %b", n, act, model(n));
            end
            if (n == 1 || n == 200 || n == 1666) begin
                compared++;
                if (act[5:4] !== {n == 200, n == 1666}) begin
                    mismatched++;
                    $display("FAIL default_ticks_n%0d: got %b want %b", n, act[5:4], {n == 200, n == 1666});
                end
            end
            if (n % 12 == 0) begin
                compared++;
                if (act[3:2] !== 2'b11) begin
                    mismatched++;
                    $display("FAIL coincide_n%0d: got %b want 11", n, act[3:2]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        repeat (2) step();
        release_reset();
        while (n < 350) step();
        #3 rst_n = 1'b0;
        #1;
        compared++;
        if (act !== 6'b111111) begin
            mismatched++;
            $display("FAIL mid_reset_async: got %b want %b", act, 6'b111111);
        end
        #3 rst_n = 1'b1;
        n = 0;
        edges = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            compared++;
            if (act !== model(n)) begin
                mismatched++;
                $display("FAIL after_reset_n%0d: got %b want %b", n, act, model(n));
            end
        end
        compared++;
        if (d_cpu !== 1'b1) begin
            mismatched++;
            $display("FAIL cpu_tick_200_after_reset: got %b want 1", d_cpu);
        end
    endtask

    task automatic test_random();
        int len;
        int hold;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(20, 400);
            for (int i = 0; i < len; i++) begin
`ifdef TIMER_PAUSE_EN
                if ($urandom_range(0, 7) == 0) pause = ~pause;
`endif
                step();
                compared++;
                if (act !== model(n)) begin
                    mismatched++;
                    $display("FAIL random_r%0d_n%0d: got %b want %b", r, n, act, model(n));
                end
            end
            hold = $urandom_range(0, 3);
            #3 rst_n = 1'b0;
            n = 0;
            #1;
            compared++;
            if (act !== 6'b111111) begin
                mismatched++;
                $display("FAIL random_reset_r%0d: got %b want %b", r, act, 6'b111111);
            end
            for (int h = 0; h < hold; h++) step();
            release_reset();
        end
`ifdef TIMER_PAUSE_EN
        pause = 1'b0;
`endif
    endtask

`ifdef TIMER_PAUSE_EN
    task automatic test_pause();
        rst_n = 1'b0;
        pause = 1'b0;
        step();
        release_reset();
        while (edges < 250) begin
            step();
            if (edges == 100) pause = 1'b1;
            if (edges == 150) pause = 1'b0;
            compared++;
            if (act !== model(n)) begin
                mismatched++;
                $display("FAIL pause_e%0d: got %b want %b", edges, act, model(n));
            end
            if (edges == 200 || edges == 250) begin
                compared++;
                if (d_cpu !== (edges == 250)) begin
                    mismatched++;
                    $display("FAIL pause_cpu_tick_e%0d: got %b want %b", edges, d_cpu, edges == 250);
                end
            end
        end
        pause = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (act !== 6'b111111) begin
            mismatched++;
            $display("FAIL reset_over_pause: got %b want %b", act, 6'b111111);
        end
        release_reset();
        pause = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        n = 0;
        edges = 0;
        test_reset();
        test_count();
        test_mid_reset();
        test_random();
`ifdef TIMER_PAUSE_EN
        test_pause();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
